// File: rtl/sfx_pkg.sv
// Shared constants and lookup functions for the sound-effect sequencer:
// note codes, note-to-period conversion and the per-effect note tables.
package sfx_pkg;

    localparam int unsigned PERIOD_W = 27;
    localparam logic [PERIOD_W-1:0] PERIOD_ONE = 27'd1;

    // Note codes: 1..7 low octave, 8..14 mid octave, 15..21 high octave
    localparam logic [4:0] NOTE_REST = 5'd0;
    localparam logic [4:0] NOTE_DO_L = 5'd1;
    localparam logic [4:0] NOTE_DO_M = 5'd8;
    localparam logic [4:0] NOTE_MI_M = 5'd10;
    localparam logic [4:0] NOTE_SO_M = 5'd12;
    localparam logic [4:0] NOTE_LA_M = 5'd13;
    localparam logic [4:0] NOTE_DO_H = 5'd15;
    localparam logic [4:0] NOTE_RE_H = 5'd16;
    localparam logic [4:0] NOTE_MI_H = 5'd17;
    localparam logic [4:0] NOTE_SO_H = 5'd19;
    localparam logic [4:0] NOTE_LA_H = 5'd20;
    localparam logic [4:0] NOTE_END  = 5'd31;

    // Tone period in clock cycles; each branch divides by a constant so it folds away
    function automatic logic [PERIOD_W-1:0] note_period(input logic [4:0] note,
                                                         input int unsigned clk_hz);
        logic [31:0] p;
        case (note)
            5'd1:    p = clk_hz / 32'd262;
            5'd2:    p = clk_hz / 32'd294;
            5'd3:    p = clk_hz / 32'd330;
            5'd4:    p = clk_hz / 32'd349;
            5'd5:    p = clk_hz / 32'd392;
            5'd6:    p = clk_hz / 32'd440;
            5'd7:    p = clk_hz / 32'd494;
            5'd8:    p = clk_hz / 32'd523;
            5'd9:    p = clk_hz / 32'd587;
            5'd10:   p = clk_hz / 32'd659;
            5'd11:   p = clk_hz / 32'd698;
            5'd12:   p = clk_hz / 32'd784;
            5'd13:   p = clk_hz / 32'd880;
            5'd14:   p = clk_hz / 32'd988;
            5'd15:   p = clk_hz / 32'd1047;
            5'd16:   p = clk_hz / 32'd1175;
            5'd17:   p = clk_hz / 32'd1319;
            5'd18:   p = clk_hz / 32'd1397;
            5'd19:   p = clk_hz / 32'd1568;
            5'd20:   p = clk_hz / 32'd1760;
            5'd21:   p = clk_hz / 32'd1976;
            default: p = 32'd0;
        endcase
        return PERIOD_W'(p);
    endfunction

    // Note played by effect 'code' at step 'step'; unknown codes end immediately
    function automatic logic [4:0] effect_rom(input logic [7:0] code, input logic [7:0] step);
        logic [4:0] n;
        case (code)
            8'd1: begin
                if (step < 8'd8)       n = NOTE_LA_M;
                else if (step < 8'd48) n = NOTE_RE_H;
                else                   n = NOTE_END;
            end
            8'd2: begin
                if (step < 8'd4)       n = NOTE_DO_M;
                else if (step < 8'd8)  n = NOTE_SO_M;
                else                   n = NOTE_END;
            end
            8'd3: begin
                if (step < 8'd6)       n = NOTE_DO_H;
                else if (step < 8'd12) n = NOTE_REST;
                else if (step < 8'd18) n = NOTE_SO_H;
                else                   n = NOTE_END;
            end
            8'd4: begin
                if (step < 8'd14)      n = 5'(8'd21 - step);
                else                   n = NOTE_END;
            end
            8'd5: begin
                if (step < 8'd40)      n = step[2] ? NOTE_MI_M : NOTE_SO_M;
                else                   n = NOTE_END;
            end
            8'd6: begin
                if (step < 8'd24)      n = step[0] ? NOTE_REST : NOTE_DO_L;
                else                   n = NOTE_END;
            end
            // No END marker: this effect finishes when the step counter runs out
            8'd7:    n = step[3] ? NOTE_MI_H : NOTE_LA_H;
            default: n = NOTE_END;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/sfx_tone_gen.sv
// Square-wave generator: a period counter restarted on every period change
// (or an explicit clear) and a duty compare scaled by the live volume.
module sfx_tone_gen
    import sfx_pkg::*;
(
    input  logic                clk,
    input  logic                rstn,
    input  logic                clear,
    input  logic [PERIOD_W-1:0] period,
    input  logic [2:0]          volume,
    output logic                b
);

    logic [PERIOD_W-1:0] cnt_r;
    logic [PERIOD_W-1:0] period_last_r;
    logic [PERIOD_W-1:0] cnt_s;
    logic [PERIOD_W-1:0] high_time_s;
    logic [3:0]          shift_s;
    logic                b_s;

    // Next counter value and output level; counter 0 always drives a pulse
    always_comb begin
        shift_s     = 4'd8 - {1'b0, volume};
        high_time_s = period >> shift_s;
        if (clear || (period != period_last_r)) begin
            cnt_s = '0;
        end else if (period == '0) begin
            cnt_s = '0;
        end else if (cnt_r >= (period - PERIOD_ONE)) begin
            cnt_s = '0;
        end else begin
            cnt_s = cnt_r + PERIOD_ONE;
        end
        if ((volume == 3'd0) || (period == '0)) begin
            b_s = 1'b0;
        end else if ((cnt_s == '0) || (cnt_s < high_time_s)) begin
            b_s = 1'b1;
        end else begin
            b_s = 1'b0;
        end
    end

    // Counter, period history and registered buzzer level
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_r         <= '0;
            period_last_r <= '0;
            b             <= 1'b0;
        end else begin
            cnt_r         <= cnt_s;
            period_last_r <= period;
            b             <= b_s;
        end
    end

endmodule

// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer: step prescaler, step counter, IDLE/PLAY control
// with priority pre-emption and stop, feeding a tone generator on pin B.
module sfx_sequencer
    import sfx_pkg::*;
#(
    parameter  int unsigned CLK_HZ    = 100_000_000,
    parameter  int unsigned STEP_HZ   = 16,
    parameter  int unsigned N_EFFECTS = 8,
    parameter  int unsigned STEPS_MAX = 64,
    localparam int unsigned CODE_W    = $clog2(N_EFFECTS),
    localparam int unsigned STEP_W    = $clog2(STEPS_MAX)
)(
    input  logic              clk,
    input  logic              rstn,
    input  logic [CODE_W-1:0] sound_code,
    input  logic              play_sound,
    input  logic              stop,
    input  logic [2:0]        volume,
    output logic              B,
    output logic              start,
    output logic              done,
    output logic              dropped,
    output logic [STEP_W-1:0] step_idx
);

    localparam int unsigned STEP_DIV = CLK_HZ / STEP_HZ;
    localparam int unsigned PRESC_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(STEP_DIV - 1);
    localparam logic [PRESC_W-1:0] PRESC_ONE  = {{(PRESC_W-1){1'b0}}, 1'b1};
    localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(STEPS_MAX - 1);
    localparam logic [STEP_W-1:0]  STEP_ONE   = {{(STEP_W-1){1'b0}}, 1'b1};

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PLAY = 1'b1;

    logic [0:0]          state_r, state_s;
    logic [CODE_W-1:0]   code_r, code_s;
    logic [STEP_W-1:0]   step_r, step_s;
    logic [PRESC_W-1:0]  presc_r, presc_s;
    logic                done_r, done_s;
    logic                dropped_r, dropped_s;
    logic                restart_s;
    logic                req_valid_s;
    logic                effect_end_s;
    logic [7:0]          step_inc_s;
    logic [PERIOD_W-1:0] period_s;

    // Next-state logic: stepping, end detection, arbitration of play/stop
    always_comb begin
        state_s      = state_r;
        code_s       = code_r;
        step_s       = step_r;
        presc_s      = presc_r;
        done_s       = 1'b0;
        dropped_s    = 1'b0;
        restart_s    = 1'b0;
        req_valid_s  = play_sound && (sound_code != '0);
        step_inc_s   = 8'(step_r) + 8'd1;
        effect_end_s = (step_r == STEP_LAST) ||
                       (effect_rom(8'(code_r), step_inc_s) == NOTE_END);
        case (state_r)
            ST_IDLE: begin
                if (req_valid_s) begin
                    state_s   = ST_PLAY;
                    code_s    = sound_code;
                    step_s    = '0;
                    presc_s   = '0;
                    restart_s = 1'b1;
                end else begin
                    state_s   = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (presc_r == PRESC_LAST) begin
                    presc_s = '0;
                    if (effect_end_s) begin
                        state_s = ST_IDLE;
                        step_s  = '0;
                        done_s  = 1'b1;
                    end else begin
                        step_s  = step_r + STEP_ONE;
                    end
                end else begin
                    presc_s = presc_r + PRESC_ONE;
                end
                // Stop beats any request; an equal-or-higher code restarts, a lower one is dropped
                if (stop) begin
                    state_s   = ST_IDLE;
                    step_s    = '0;
                    presc_s   = '0;
                    done_s    = 1'b0;
                    dropped_s = req_valid_s;
                end else if (req_valid_s && (sound_code >= code_r)) begin
                    state_s   = ST_PLAY;
                    code_s    = sound_code;
                    step_s    = '0;
                    presc_s   = '0;
                    done_s    = 1'b0;
                    restart_s = 1'b1;
                end else if (req_valid_s) begin
                    dropped_s = 1'b1;
                end else begin
                    dropped_s = 1'b0;
                end
            end
            default: begin
                state_s = ST_IDLE;
                code_s  = '0;
                step_s  = '0;
                presc_s = '0;
            end
        endcase
        // Period for the step that becomes current on this edge, so B follows start exactly
        if (state_s == ST_PLAY) begin
            period_s = note_period(effect_rom(8'(code_s), 8'(step_s)), CLK_HZ);
        end else begin
            period_s = '0;
        end
    end

    // Sequencer state registers and output pulses
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r   <= ST_IDLE;
            code_r    <= '0;
            step_r    <= '0;
            presc_r   <= '0;
            done_r    <= 1'b0;
            dropped_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            code_r    <= code_s;
            step_r    <= step_s;
            presc_r   <= presc_s;
            done_r    <= done_s;
            dropped_r <= dropped_s;
        end
    end

    assign start    = (state_r == ST_PLAY);
    assign done     = done_r;
    assign dropped  = dropped_r;
    assign step_idx = step_r;

    sfx_tone_gen u_tone (
        .clk    (clk),
        .rstn   (rstn),
        .clear  (restart_s),
        .period (period_s),
        .volume (volume),
        .b      (B)
    );

endmodule

// File: tb/tb_sfx_sequencer.sv
// Self-checking bench for sfx_sequencer: done/dropped pulses are scored
// against a queue of expected events; tone and state are checked inline.
module tb_sfx_sequencer;

    localparam int CLK_HZ   = 100_000;
    localparam int STEP_HZ  = 1000;
    localparam int SD       = CLK_HZ / STEP_HZ;
    localparam int K_NONE   = -1;
    localparam int K_DONE   = 0;
    localparam int K_DROP   = 1;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    ev_t exp_q[$];

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       play_sound = 1'b0;
    logic       stop = 1'b0;
    logic [2:0] sound_code = 3'd0;
    logic [2:0] volume = 3'd7;
    logic       B, start, done, dropped;
    logic [5:0] step_idx;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    sfx_sequencer #(
        .CLK_HZ    (CLK_HZ),
        .STEP_HZ   (STEP_HZ),
        .N_EFFECTS (8),
        .STEPS_MAX (64)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .sound_code (sound_code),
        .play_sound (play_sound),
        .stop       (stop),
        .volume     (volume),
        .B          (B),
        .start      (start),
        .done       (done),
        .dropped    (dropped),
        .step_idx   (step_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic note_pulse(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            check_val("unexpected_pulse", kind, K_NONE);
        end else begin
            e = exp_q.pop_front();
            check_val("pulse_kind", kind, e.kind);
            check_val("pulse_cycle", cyc, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) note_pulse(K_DONE);
        if (dropped === 1'b1) note_pulse(K_DROP);
    end

    // Drive one request; the expected pulse is queued before the DUT can emit it
    task automatic request(input logic [2:0] code, input logic stp, input int kind,
                           input int delay, output int acc);
        @(negedge clk);
        sound_code = code;
        play_sound = 1'b1;
        stop = stp;
        acc = cyc + 1;
        if (kind != K_NONE) exp_q.push_back('{kind: kind, cyc: acc + delay});
        @(negedge clk);
        play_sound = 1'b0;
        stop = 1'b0;
        sound_code = 3'd0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // High time and period of the next complete B cycle; -1 on timeout
    task automatic measure_tone(output int hi, output int per);
        int t;
        hi = -1;
        per = -1;
        t = 0;
        while (B !== 1'b0 && t < 1000) begin @(negedge clk); t++; end
        t = 0;
        while (B !== 1'b1 && t < 1000) begin @(negedge clk); t++; end
        if (B === 1'b1) begin
            hi = 0;
            while (B === 1'b1 && hi < 1000) begin hi++; @(negedge clk); end
            per = hi;
            while (B === 1'b0 && per < 2000) begin per++; @(negedge clk); end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_B"}, B, 1'b0);
        check_val({tag, "_start"}, start, 1'b0);
        check_val({tag, "_done"}, done, 1'b0);
        check_val({tag, "_dropped"}, dropped, 1'b0);
        check_val({tag, "_step"}, step_idx, 6'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc, acc2, hi, per, lat, highs;

        // Reset state
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rstn = 1'b1;
        repeat (3) @(negedge clk);

        // 1: effect 1 at full volume, tone shape and exact completion time
        volume = 3'd7;
        request(3'd1, 1'b0, K_DONE, 48 * SD, acc);
        check_val("t1_start", start, 1'b1);
        check_val("t1_step0", step_idx, 6'd0);
        lat = 0;
        while (B !== 1'b1 && lat < 4) begin @(negedge clk); lat++; end
        check_val("t1_b_rise_latency_ok", (lat <= 3), 1'b1);
        measure_tone(hi, per);
        check_val("t1_hi_113", hi, 56);
        check_val("t1_per_113", per, 113);
        wait_until(acc + 8 * SD + 10);
        measure_tone(hi, per);
        check_val("t1_hi_85", hi, 42);
        check_val("t1_per_85", per, 85);
        wait_until(acc + 25 * SD + 37);
        check_val("t1_step25", step_idx, 6'd25);
        wait_until(acc + 48 * SD - 1);
        check_val("t1_start_before_end", start, 1'b1);
        wait_until(acc + 48 * SD);
        check_val("t1_start_end", start, 1'b0);
        check_val("t1_B_end", B, 1'b0);
        repeat (5) @(negedge clk);

        // 2: lower-priority request dropped, higher one pre-empts, code 7 runs to wrap
        request(3'd5, 1'b0, K_NONE, 0, acc);
        wait_until(acc + 10 * SD + 50);
        request(3'd2, 1'b0, K_DROP, 0, acc2);
        check_val("t2_start_after_drop", start, 1'b1);
        check_val("t2_step_after_drop", step_idx, 6'd10);
        wait_until(acc + 12 * SD + 10);
        check_val("t2_step12", step_idx, 6'd12);
        request(3'd7, 1'b0, K_DONE, 64 * SD, acc2);
        check_val("t2_preempt_step", step_idx, 6'd0);
        check_val("t2_preempt_start", start, 1'b1);
        wait_until(acc2 + 63 * SD + 5);
        check_val("t2_step63", step_idx, 6'd63);
        wait_until(acc2 + 64 * SD + 2);
        check_val("t2_wrap_start", start, 1'b0);
        repeat (5) @(negedge clk);

        // 3: stop with a simultaneous request at step 20
        request(3'd1, 1'b0, K_NONE, 0, acc);
        wait_until(acc + 20 * SD + 30);
        request(3'd7, 1'b1, K_DROP, 0, acc2);
        check_val("t3_start", start, 1'b0);
        check_val("t3_B", B, 1'b0);
        wait_until(acc + 48 * SD + 10);
        check_val("t3_still_idle", start, 1'b0);

        // 4: mute then minimum volume mid-effect
        request(3'd1, 1'b0, K_DONE, 48 * SD, acc);
        wait_until(acc + 50);
        volume = 3'd0;
        @(negedge clk);
        highs = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (B !== 1'b0) highs++;
        end
        check_val("t4_mute_highs", highs, 0);
        check_val("t4_mute_start", start, 1'b1);
        check_val("t4_mute_step", step_idx, 6'((cyc - acc) / SD));
        volume = 3'd1;
        measure_tone(hi, per);
        check_val("t4_vol1_hi", hi, 1);
        check_val("t4_vol1_per", per, 113);
        volume = 3'd7;
        wait_until(acc + 48 * SD + 2);
        check_val("t4_end_start", start, 1'b0);

        // 5: reset mid-effect, then a code-0 request
        request(3'd1, 1'b0, K_NONE, 0, acc);
        wait_until(acc + 30 * SD + 20);
        check_val("t5_step30", step_idx, 6'd30);
        rstn = 1'b0;
        @(negedge clk);
        check_all_zero("t5_rst");
        rstn = 1'b1;
        request(3'd0, 1'b0, K_NONE, 0, acc2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("t5_code0_start", start, 1'b0);
        end
        wait_until(acc + 48 * SD + 20);
        check_val("t5_idle_start", start, 1'b0);

        check_val("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
